// File: rtl/product_accumulator.sv
// Product accumulator: sums signed products from an upstream multiplier,
// then rounds, shifts and saturates the finished sum into a registered result.
// A term flagged in_last closes the sum. The result is held until downstream
// takes it, and the next accepted term starts a fresh sum.
module product_accumulator #(
  parameter int P_WIDTH   = 48,
  parameter int ACC_WIDTH = 56,
  parameter int OUT_WIDTH = 24,
  parameter int SHIFT     = 23,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [P_WIDTH-1:0]   in_P,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 out_ovf,
  output logic [CNT_WIDTH-1:0] out_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic signed [ACC_WIDTH:0]   ONE_W      = {{ACC_WIDTH{1'b0}}, 1'b1};
  localparam int                          RND_POS    = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH:0]   ROUND_BIAS = (SHIFT > 0) ? (ONE_W << RND_POS) : '0;
  localparam logic signed [ACC_WIDTH:0]   OUT_MAX    = (ONE_W << (OUT_WIDTH - 1)) - ONE_W;
  localparam logic signed [ACC_WIDTH:0]   OUT_MIN    = ~OUT_MAX;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX    = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN    = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                       state, state_next;
  logic                         accept;
  logic                         first_term;
  logic signed [ACC_WIDTH-1:0]  acc, acc_next, p_ext;
  logic [CNT_WIDTH-1:0]         count, count_next;
  logic                         ovf, ovf_next;
  logic signed [ACC_WIDTH:0]    sum_g, rnd, r;
  logic [OUT_WIDTH-1:0]         data_next;
  logic                         sat_next;

  // State register: reset always lands in ACCUM.
  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  // Next state: close a sum on its last term, release on downstream accept.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (in_valid && in_last) state_next = HOLD;
      HOLD:    if (out_ready)           state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == HOLD);
    accept    = in_valid && (state == ACCUM);
  end

  // Next accumulator value with a guard bit, then round, shift and clip it.
  always_comb begin
    p_ext      = ACC_WIDTH'($signed(in_P));
    sum_g      = {acc[ACC_WIDTH-1], acc} + {p_ext[ACC_WIDTH-1], p_ext};
    acc_next   = acc;
    count_next = count;
    ovf_next   = ovf;
    if (first_term) begin
      acc_next   = p_ext;
      count_next = CNT_WIDTH'(1);
      ovf_next   = 1'b0;
    end else begin
      count_next = count + 1'b1;
      if (sum_g[ACC_WIDTH] != sum_g[ACC_WIDTH-1]) begin
        acc_next = sum_g[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        ovf_next = 1'b1;
      end else begin
        acc_next = sum_g[ACC_WIDTH-1:0];
      end
    end
    rnd = {acc_next[ACC_WIDTH-1], acc_next} + ROUND_BIAS;
    r   = rnd >>> SHIFT;
    if (r > OUT_MAX) begin
      data_next = OUT_MAX[OUT_WIDTH-1:0];
      sat_next  = 1'b1;
    end else if (r < OUT_MIN) begin
      data_next = OUT_MIN[OUT_WIDTH-1:0];
      sat_next  = 1'b1;
    end else begin
      data_next = r[OUT_WIDTH-1:0];
      sat_next  = 1'b0;
    end
  end

  // Running sum state; a last term re-arms the first-term load for the next sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      first_term <= 1'b1;
    end else if (accept) begin
      acc        <= acc_next;
      count      <= count_next;
      ovf        <= ovf_next;
      first_term <= in_last;
    end
  end

  // Result registers load once per sum and hold steady through HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_ovf   <= 1'b0;
      out_count <= '0;
    end else if (accept && in_last) begin
      out_data  <= data_next;
      out_sat   <= sat_next;
      out_ovf   <= ovf_next;
      out_count <= count_next;
    end
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter P_WIDTH, default 48, width of signed product input; equals A_WIDTH+B_WIDTH of the upstream multiplier.
REQ-002 Parameter ACC_WIDTH, default 56, signed accumulator width; SHALL be >= P_WIDTH.
REQ-003 Parameter OUT_WIDTH, default 24, signed result width; SHALL be <= ACC_WIDTH.
REQ-004 Parameter SHIFT, default 23, arithmetic right shift applied before output; range 0..ACC_WIDTH-OUT_WIDTH.
REQ-005 Parameter CNT_WIDTH, default 16, width of the term counter.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  in_P/in_last are valid this cycle.
REQ-009 in_P  input  P_WIDTH  signed product (upstream out_C).
REQ-010 in_last  input  1  marks final term of the current sum.
REQ-011 in_ready  output  1  block accepts a term this cycle.
REQ-012 out_valid  output  1  out_data/out_sat/out_ovf/out_count are valid.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_data  output  OUT_WIDTH  rounded, shifted, saturated sum.
REQ-015 out_sat  output  1  out_data was clipped to OUT_WIDTH range.
REQ-016 out_ovf  output  1  accumulator saturated at least once during this sum.
REQ-017 out_count  output  CNT_WIDTH  number of terms in this sum (wraps modulo 2^CNT_WIDTH).

Function
REQ-018 Two states: ACCUM and HOLD; reset enters ACCUM.
REQ-019 in_ready SHALL be 1 exactly in ACCUM; a term is accepted when in_valid && in_ready.
REQ-020 First accepted term after reset or after a result handoff SHALL load acc = sign-extended in_P, count = 1, ovf = 0.
REQ-021 Later accepted terms: acc <= acc + sign-extended in_P, count <= count + 1, computed with one guard bit.
REQ-022 If the guard-bit sum exceeds the signed ACC_WIDTH range, acc SHALL clamp to max/min by sum sign and ovf SHALL set (sticky until next first term).
REQ-023 Accepting a term with in_last=1 SHALL move to HOLD on the same edge, with that term included; out_valid=1 the following cycle (latency 1 clock from last term).
REQ-024 A single term with in_last=1 on the first beat SHALL form a complete 1-term sum.
REQ-025 Rounding: r = (acc + 2^(SHIFT-1)) >>> SHIFT for SHIFT>0, r = acc for SHIFT=0, computed in ACC_WIDTH+1 bits (no wrap).
REQ-026 out_data = r clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; out_sat=1 iff clamping occurred.
REQ-027 out_data, out_sat, out_ovf, out_count SHALL be registered and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 In HOLD, out_valid && out_ready SHALL return to ACCUM and drop out_valid on the same edge; next accepted term is a first term.
REQ-029 in_valid while in HOLD SHALL be ignored (no accumulation, no count change); upstream holds its data.
REQ-030 out_ready while out_valid=0 SHALL have no effect.
REQ-031 Cycles with in_valid=0 in ACCUM SHALL leave acc, count, ovf unchanged (gaps allowed mid-sum).

Reset
REQ-032 reset=1 at any edge SHALL force ACCUM, acc=0, count=0, ovf=0, out_valid=0, out_data=0, out_sat=0, out_ovf=0, out_count=0; in_ready=1 from the first cycle after reset deasserts.
REQ-033 Reset mid-sum or during HOLD SHALL discard the partial sum/pending result; no out_valid follows.

Verification
REQ-034 Defaults, SHIFT=0, OUT_WIDTH=24: terms 100, -30, 5(last), out_ready=1 -> out_valid one cycle after last, out_data=75, out_count=3, out_sat=0, out_ovf=0.
REQ-035 SHIFT=4: single term 24 with last -> out_data=2 (24/16=1.5 rounds up); term -24 -> out_data=-1 (round half up).
REQ-036 SHIFT=0: terms 2^23, 2^23(last) -> out_data=8388607, out_sat=1; terms -2^23, -1(last) -> out_data=-8388608, out_sat=1.
REQ-037 ACC_WIDTH=P_WIDTH=48: terms 2^46, 2^46, -1(last) -> acc clamps to 2^47-1 then 2^47-2, out_ovf=1.
REQ-038 out_ready=0 for 5 cycles after out_valid with in_valid held 1 -> out_* stable, in_ready=0, count/acc unchanged; on out_ready=1 next term starts a fresh sum.
REQ-039 reset pulsed after 2 of 4 terms -> no out_valid; then terms 7, 8(last) -> out_data=15, out_count=2.
